alu_cmd_sequencer: RTL and testbench

Registered command front-end for the 8-bit combinational ALU (opcode s[3:0], operands a/b[7:0], result y[15:0]). Accepts operand/opcode commands over a valid/ready handshake into a small FIFO, drives the ALU inputs from registers, and captures each result with its opcode and an error flag on a valid/ready output port. Sits directly upstream of the ALU and also takes its result back; it is the only block that drives the ALU.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_cmd_fifo.sv | 58 +++++
 rtl/alu_cmd_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and command layout for the ALU command sequencer.
// Optional feature macro: DIVZERO_TRAP_EN (traps divide/modulus by zero).
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_MOD  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_XNOR = 4'd8;
   localparam logic [3:0] OP_LAST = 4'd8;

   localparam logic [15:0] DIVZERO_RESULT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      HOLD
   } state_t;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] b;
      logic [7:0] a;
   } cmd_t;

   function automatic logic op_valid(input logic [3:0] op);
      return op <= OP_LAST;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO holding {op,b,a}; pointers wrap modulo DEPTH.
// DEPTH must be a power of two, at least 2.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  cmd_t din,
   output cmd_t dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // pointers and occupancy; full blocks push even when popping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Registered command front-end for the 8-bit ALU: FIFO in, result port out.
// Optional feature macro: DIVZERO_TRAP_EN (div/mod by zero -> 16'hFFFF, err).
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   input  logic [3:0]  in_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_s,
   input  logic [15:0] alu_y,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_y,
   output logic [3:0]  out_op,
   output logic        out_err
);

   state_t state;
   state_t next_state;
   cmd_t   in_cmd;
   cmd_t   head;
   logic   full;
   logic   empty;
   logic   pop;
   logic   capture;
   logic   trap;

   assign in_cmd    = '{op: in_op, b: in_b, a: in_a};
   assign in_ready  = rst_n && !full;
   assign out_valid = state == HOLD;

`ifdef DIVZERO_TRAP_EN
   assign trap = (alu_s == OP_DIV || alu_s == OP_MOD) && alu_b == 8'd0;
`else
   assign trap = 1'b0;
`endif

   alu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid && in_ready),
      .pop   (pop),
      .din   (in_cmd),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next state, FIFO pop and result capture strobes
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      capture    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               next_state = EXEC;
            end
         end
         EXEC: begin
            capture    = 1'b1;
            next_state = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               if (!empty) begin
                  pop        = 1'b1;
                  next_state = EXEC;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // ALU operand registers, loaded only when a command is popped
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a <= '0;
         alu_b <= '0;
         alu_s <= '0;
      end else if (pop) begin
         alu_a <= head.a;
         alu_b <= head.b;
         alu_s <= head.op;
      end
   end

   // result capture; invalid opcodes never pass the ALU value through
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_y   <= '0;
         out_op  <= '0;
         out_err <= 1'b0;
      end else if (capture) begin
         out_op <= alu_s;
         if (!op_valid(alu_s)) begin
            out_y   <= 16'h0000;
            out_err <= 1'b1;
         end else if (trap) begin
            out_y   <= DIVZERO_RESULT;
            out_err <= 1'b1;
         end else begin
            out_y   <= alu_y;
            out_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU and
// a queue-based result scoreboard; honours DIVZERO_TRAP_EN when defined.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic [3:0]  in_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [3:0]  alu_s;
   logic [15:0] alu_y;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_y;
   logic [3:0]  out_op;
   logic        out_err;

   int checks = 0;
   int errors = 0;

`ifdef DIVZERO_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic [15:0] y;
      logic [3:0]  op;
      logic        err;
   } res_t;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  op;
      logic [15:0] y;
      logic        err;
   } vec_t;

   res_t exp_q[$];
   vec_t vt[7];

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_s     (alu_s),
      .alu_y     (alu_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_op    (out_op),
      .out_err   (out_err)
   );

   function automatic logic [15:0] alu_fn(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [3:0] s
   );
      logic [7:0] t;
      case (s)
         4'd0: return 16'(a) + 16'(b);
         4'd1: return 16'(a) - 16'(b);
         4'd2: return 16'(a) * 16'(b);
         4'd3: return (b == 0) ? 16'h00FF : 16'(a / b);
         4'd4: return (b == 0) ? 16'h00FF : 16'(a % b);
         4'd5: return 16'(a & b);
         4'd6: return 16'(a | b);
         4'd7: return 16'(a ^ b);
         4'd8: begin
            t = ~(a ^ b);
            return {8'h00, t};
         end
         default: return 16'hBAD0;
      endcase
   endfunction

   assign alu_y = alu_fn(alu_a, alu_b, alu_s);

   function automatic res_t model(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [3:0] op
   );
      res_t r;
      r.op = op;
      if (op > 4'd8) begin
         r.y   = 16'h0000;
         r.err = 1'b1;
      end else if (TRAP && (op == 4'd3 || op == 4'd4) && b == 0) begin
         r.y   = 16'hFFFF;
         r.err = 1'b1;
      end else begin
         r.y   = alu_fn(a, b, op);
         r.err = 1'b0;
      end
      return r;
   endfunction

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // one clock: scoreboard on the handshakes seen before the edge
   task automatic tick();
      res_t e;
      @(negedge clk);
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_result", 32'd1, 32'd0);
            end else if (out_ready) begin
               e = exp_q.pop_front();
               chk("sb_y", 32'(out_y), 32'(e.y));
               chk("sb_op", 32'(out_op), 32'(e.op));
               chk("sb_err", 32'(out_err), 32'(e.err));
            end else begin
               chk("sb_stall_y", 32'(out_y), 32'(exp_q[0].y));
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_a, in_b, in_op));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op);
      bit acc;
      bit done;
      done     = 1'b0;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_valid = 1'b1;
      for (int i = 0; i < 30 && !done; i++) begin
         acc = in_ready;
         tick();
         done = acc;
      end
      in_valid = 1'b0;
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      bit acc;
      int accepted;
      int cyc;

      vt[0] = '{8'd200, 8'd100, 4'd0, 16'd300, 1'b0};
      vt[1] = '{8'hFF, 8'hFF, 4'd2, 16'hFE01, 1'b0};
      vt[2] = '{8'd5, 8'd7, 4'd1, 16'hFFFE, 1'b0};
      vt[3] = '{8'h12, 8'h34, 4'hA, 16'h0000, 1'b1};
`ifdef DIVZERO_TRAP_EN
      vt[4] = '{8'd9, 8'd0, 4'd3, 16'hFFFF, 1'b1};
`else
      vt[4] = '{8'd9, 8'd0, 4'd3, 16'h00FF, 1'b0};
`endif
      vt[5] = '{8'h3C, 8'h0F, 4'd8, 16'h00CC, 1'b0};
      vt[6] = '{8'd100, 8'd7, 4'd4, 16'h0002, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_alu_s", 32'(alu_s), 32'd0);
      chk("rst_out_y", 32'(out_y), 32'd0);
      chk("rst_out_op", 32'(out_op), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // table vectors: latency and result per command
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send(vt[i].a, vt[i].b, vt[i].op);
         tick();
         chk($sformatf("v%0d_lat1", i), 32'(out_valid), 32'd0);
         tick();
         chk($sformatf("v%0d_lat2", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_y", i), 32'(out_y), 32'(vt[i].y));
         chk($sformatf("v%0d_op", i), 32'(out_op), 32'(vt[i].op));
         chk($sformatf("v%0d_err", i), 32'(out_err), 32'(vt[i].err));
         tick();
         tick();
      end

      // stall: 5 accepted, 6th refused until results drain
      out_ready = 1'b0;
      accepted  = 0;
      in_valid  = 1'b1;
      for (cyc = 0; cyc < 40 && accepted < 5; cyc++) begin
         in_a  = 8'(10 + accepted);
         in_b  = 8'(3 + accepted);
         in_op = 4'(accepted);
         acc   = in_ready;
         tick();
         if (acc) accepted++;
      end
      chk("stall_accepts", 32'(accepted), 32'd5);
      in_a  = 8'd77;
      in_op = 4'd0;
      repeat (3) begin
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      in_valid  = 1'b0;
      chk("stall_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      for (cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) tick();
      chk("stall_drained", 32'(exp_q.size()), 32'd0);
      tick();
      chk("stall_idle", 32'(out_valid), 32'd0);

      // reset while holding a result with 3 queued
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(8'(40 + i), 8'd2, 4'd2);
      for (cyc = 0; cyc < 10 && !out_valid; cyc++) tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_queued", 32'(exp_q.size()), 32'd4);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (5) begin
         chk("no_stale", 32'(out_valid), 32'd0);
         tick();
      end

      // randomized traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = 8'($urandom);
         in_b      = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
         in_op     = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (cyc = 0; cyc < 60 && (exp_q.size() != 0 || out_valid); cyc++) tick();
      chk("rand_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
